dbus_sram_responder: RTL and testbench
======================================

# dbus_sram_responder

Data-bus responder that terminates the core's `dreq`/`dresp` handshake with an on-chip 64-bit-wide SRAM model. It sits on the far side of the core's memory stage (simulation top or SoC wrapper) in place of the external memory system. It serves one transaction at a time with a programmable wait latency and byte-strobed writes, so MEM-stage stall (`stallM`) and flush behaviour can be exercised deterministically.

## Interface
Parameters:
- `MEM_WORDS`, 4096: number of 64-bit words; power of two.
- `LATENCY`, 2: wait cycles between acceptance and response; 0–15.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `dreq` in `dbus_req_t`: `valid`, `addr[63:0]`, `size` (msize_t), `strobe[7:0]`, `data[63:0]`. `strobe==0` means read.
- `dresp` out `dbus_resp_t`: `addr_ok`, `data_ok`, `data[63:0]`.

## Operation
- Address decode: `off = addr - BASE_ADDR`; `idx = off[63:3]`.
  - In range iff `addr >= BASE_ADDR` and `idx < MEM_WORDS`.
  - `addr[2:0]` and `size` are ignored for indexing. The requester supplies lane-aligned `strobe` and `data`, and performs lane extraction and sign extension itself.
- FSM states: IDLE, WAIT, RESP. Register `cnt` is 4 bits.
- IDLE:
  - If `dreq.valid`, latch `addr`, `strobe`, `data` and the in-range flag.
  - Set `cnt = LATENCY`.
  - Go to WAIT, or directly to RESP if `LATENCY==0`.
- WAIT:
  - If `dreq.valid==0`, abort: go to IDLE with no write and no response pulse. This is a flushed request.
  - Else if `cnt==1`, go to RESP; otherwise decrement `cnt`.
- RESP:
  - Drive `addr_ok=data_ok=1` for exactly this one cycle.
  - `dresp.data` = the stored word as it was before this transaction's write (read-before-write). Returns 0 if out of range.
  - On this cycle's edge, write every byte lane `i` with `strobe[i]=1` into the word, if in range. Out-of-range writes are dropped silently.
  - Always return to IDLE.
  - The request is not re-checked in RESP. A response already in RESP always completes.
- Outside RESP: `addr_ok=data_ok=0` and `dresp.data=0`.
- Request fields may change after acceptance. Only the latched copies are used.
- A new `valid` in the cycle right after RESP is a new transaction, accepted in IDLE.
- Memory contents are not reset. The bench initialises them via hierarchical write or `$readmemh`.

## Timing
- Reset: state=IDLE, `cnt=0`, `addr_ok=0`, `data_ok=0`, `dresp.data=0`.
  - Reset asserted mid-transaction discards it with no write.
  - The first acceptance can occur in the first cycle with `reset==0`.
- Request first seen in IDLE at cycle T: `data_ok` is high at cycle T+LATENCY+1.
  - `LATENCY=0`: response at T+1.
  - `LATENCY=2`: response at T+3.
- The write becomes visible to any transaction accepted at T+LATENCY+2 or later.
- Throughput: one transaction per LATENCY+2 cycles with back-to-back `valid`.
- `addr_ok` and `data_ok` are always identical. This block never splits address and data phases.
- Abort granularity: `valid` must be high in every WAIT cycle. The check is made on each WAIT cycle, not on the RESP cycle.

## Test plan
- Read, `LATENCY=2`: preload word 0 = 64'h1122_3344_5566_7788; hold `valid`, `addr=0x8000_0000`, `strobe=0` from cycle 1 → `data_ok` high only in cycle 4 with data 64'h1122_3344_5566_7788; back to idle in cycle 5.
- Strobed write then read: write `addr=0x8000_0008`, `strobe=8'h0F`, `data=64'hAAAA_BBBB_CCCC_DDDD` over preloaded 64'hFFFF_FFFF_FFFF_FFFF → write response returns old value 64'hFFFF_FFFF_FFFF_FFFF; a following read of the same address returns 64'hFFFF_FFFF_CCCC_DDDD.
- Abort: start a write `strobe=8'hFF`, `data=1` to word 2; drop `valid` in the first WAIT cycle → no `data_ok` pulse; a subsequent read of word 2 returns the unchanged preload.
- Out of range: read `addr=0x7FFF_FFF8` and read `addr=BASE+8*MEM_WORDS` → each completes with `data_ok` and data 0; a write to `BASE+8*MEM_WORDS` alters no word (check words 0 and MEM_WORDS-1).
- `LATENCY=0` back-to-back: four consecutive reads with `valid` held and the address changed after each `data_ok` → `data_ok` every second cycle with correct data each time.
- Reset mid-WAIT: assert `reset` for one cycle during a pending write to word 3 → `dresp` all zero through the next cycle; word 3 unchanged; a new request right after reset completes at T+LATENCY+1.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: terminates the core dreq/dresp handshake with a
// 64-bit-wide on-chip SRAM model, programmable wait latency, byte-strobed writes.

package dbus_sram_responder_pkg;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

endpackage

module dbus_sram_responder
   import dbus_sram_responder_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 4096,
   parameter int unsigned LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp
);

   localparam int unsigned AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [3:0]  LAT     = 4'(LATENCY);
   localparam logic [60:0] WORDS61 = 61'(MEM_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        w_accept;
   logic        w_resp_nxt;

   logic [AW-1:0] r_idx;
   logic          r_inrange;
   logic [7:0]    r_strobe;
   logic [63:0]   r_data;

   logic          r_resp_ok;
   logic [63:0]   r_rdata;

   logic [63:0]   r_mem [MEM_WORDS];

   // Address decode of the live request (only used on acceptance in IDLE)
   logic [63:0]   w_off;
   logic          w_req_inrange;
   logic [AW-1:0] w_req_idx;

   assign w_off         = dreq.addr - BASE_ADDR;
   assign w_req_inrange = (dreq.addr >= BASE_ADDR) && (w_off[63:3] < WORDS61);
   assign w_req_idx     = w_off[AW+2:3];

   // Size and sub-word offset do not affect word indexing
   logic w_unused;
   assign w_unused = ^{w_off[2:0], dreq.size};

   // Word read for the response: the live request when entering RESP straight from IDLE
   logic [AW-1:0] w_rd_idx;
   logic          w_rd_inrange;

   assign w_rd_idx     = (r_state == ST_IDLE) ? w_req_idx     : r_idx;
   assign w_rd_inrange = (r_state == ST_IDLE) ? w_req_inrange : r_inrange;

   // FSM state and wait counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, counter and response-enable decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_resp_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (dreq.valid) begin
               w_accept  = 1'b1;
               w_cnt_nxt = LAT;
               if (LAT == 4'd0) begin
                  w_state_nxt = ST_RESP;
                  w_resp_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!dreq.valid) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == 4'd1) begin
               w_state_nxt = ST_RESP;
               w_resp_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Latch request fields at acceptance; later request changes are ignored
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx     <= '0;
         r_inrange <= 1'b0;
         r_strobe  <= 8'd0;
         r_data    <= 64'd0;
      end else if (w_accept) begin
         r_idx     <= w_req_idx;
         r_inrange <= w_req_inrange;
         r_strobe  <= dreq.strobe;
         r_data    <= dreq.data;
      end
   end

   // Registered response: captures the pre-write word on entry to RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resp_ok <= 1'b0;
         r_rdata   <= 64'd0;
      end else begin
         r_resp_ok <= w_resp_nxt;
         r_rdata   <= (w_resp_nxt && w_rd_inrange) ? r_mem[w_rd_idx] : 64'd0;
      end
   end

   // Byte-lane write at the end of RESP; out-of-range or reset cycles write nothing
   always_ff @(posedge clk) begin
      if (!reset && (r_state == ST_RESP) && r_inrange) begin
         for (int i = 0; i < 8; i++) begin
            if (r_strobe[i]) begin
               r_mem[r_idx][8*i +: 8] <= r_data[8*i +: 8];
            end
         end
      end
   end

   assign dresp = '{addr_ok: r_resp_ok, data_ok: r_resp_ok, data: r_rdata};

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed self-checking bench for dbus_sram_responder (LATENCY=2 and LATENCY=0 instances).
module tb_dbus_sram_responder;
   import dbus_sram_responder_pkg::*;

   localparam logic [63:0] BASE = 64'h8000_0000;

   localparam logic [63:0] W0    = 64'h1122_3344_5566_7788;
   localparam logic [63:0] W1    = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] W2    = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] W3    = 64'hDEAD_BEEF_0BAD_F00D;
   localparam logic [63:0] WLAST = 64'h5A5A_5A5A_A5A5_A5A5;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   dbus_req_t  req;
   dbus_resp_t resp;
   dbus_req_t  req0;
   dbus_resp_t resp0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] l0_vals [4] = '{64'h0000_0000_0000_00A0, 64'hB1B1_0000_0000_00B1,
                                64'hC2C2_C2C2_0000_00C2, 64'hD3D3_D3D3_D3D3_D3D3};

   always #5 clk = ~clk;

   dbus_sram_responder #(.MEM_WORDS(4096), .LATENCY(2), .BASE_ADDR(BASE)) u_dut (
      .clk   (clk),
      .reset (reset),
      .dreq  (req),
      .dresp (resp)
   );

   dbus_sram_responder #(.MEM_WORDS(16), .LATENCY(0), .BASE_ADDR(BASE)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .dreq  (req0),
      .dresp (resp0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
      req.valid  = v;
      req.addr   = a;
      req.size   = MSIZE8;
      req.strobe = s;
      req.data   = d;
   endtask

   task automatic drive0(input logic v, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
      req0.valid  = v;
      req0.addr   = a;
      req0.size   = MSIZE8;
      req0.strobe = s;
      req0.data   = d;
   endtask

   // One transaction on the LATENCY=2 instance; returns cycles to data_ok (-1 on timeout)
   task automatic txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                      output logic [63:0] rd, output logic aok, output int lat);
      logic done;
      done = 1'b0;
      lat  = -1;
      rd   = 64'd0;
      aok  = 1'b0;
      drive(1'b1, a, s, d);
      for (int i = 1; i <= 20; i++) begin
         if (!done) begin
            step();
            if (resp.data_ok) begin
               done = 1'b1;
               lat  = i;
               rd   = resp.data;
               aok  = resp.addr_ok;
            end
         end
      end
      req.valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 64'd0, 8'd0, 64'd0);
      drive0(1'b0, 64'd0, 8'd0, 64'd0);
      step();
      step();
      n_tests++;
      if (resp !== '0) begin
         n_fail++;
         $display("FAIL reset_resp: got %h expected 0", resp);
      end
      n_tests++;
      if (resp0 !== '0) begin
         n_fail++;
         $display("FAIL reset_resp0: got %h expected 0", resp0);
      end
      reset = 1'b0;
   endtask

   task automatic preload();
      logic [63:0] rd;
      logic        aok;
      int          lat;
      txn(BASE,                8'hFF, W0,    rd, aok, lat);
      txn(BASE + 64'd8,        8'hFF, W1,    rd, aok, lat);
      txn(BASE + 64'd16,       8'hFF, W2,    rd, aok, lat);
      txn(BASE + 64'd24,       8'hFF, W3,    rd, aok, lat);
      txn(BASE + 64'h7FF8,     8'hFF, WLAST, rd, aok, lat);
   endtask

   task automatic test_read();
      drive(1'b1, BASE, 8'h00, 64'd0);
      step();
      n_tests++;
      if (resp.data_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL read_c2_data_ok: got %b expected 0", resp.data_ok);
      end
      step();
      n_tests++;
      if (resp.data_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL read_c3_data_ok: got %b expected 0", resp.data_ok);
      end
      step();
      n_tests++;
      if (resp.data_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL read_c4_data_ok: got %b expected 1", resp.data_ok);
      end
      n_tests++;
      if (resp.addr_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL read_c4_addr_ok: got %b expected 1", resp.addr_ok);
      end
      n_tests++;
      if (resp.data !== W0) begin
         n_fail++;
         $display("FAIL read_c4_data: got %h expected %h", resp.data, W0);
      end
      step();
      n_tests++;
      if (resp !== '0) begin
         n_fail++;
         $display("FAIL read_c5_idle: got %h expected 0", resp);
      end
      req.valid = 1'b0;
      step();
   endtask

   task automatic test_strobe_write();
      logic [63:0] rd;
      logic        aok;
      int          lat;
      txn(BASE + 64'd8, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, rd, aok, lat);
      n_tests++;
      if (rd !== W1) begin
         n_fail++;
         $display("FAIL strobe_write_old: got %h expected %h", rd, W1);
      end
      n_tests++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL strobe_write_latency: got %0d expected 3", lat);
      end
      txn(BASE + 64'd8, 8'h00, 64'd0, rd, aok, lat);
      n_tests++;
      if (rd !== 64'hFFFF_FFFF_CCCC_DDDD) begin
         n_fail++;
         $display("FAIL strobe_write_readback: got %h expected ffffffffccccdddd", rd);
      end
   endtask

   task automatic test_abort();
      logic [63:0] rd;
      logic        aok;
      int          lat;
      drive(1'b1, BASE + 64'd16, 8'hFF, 64'd1);
      step();
      req.valid = 1'b0;
      step();
      n_tests++;
      if (resp.data_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_c1_data_ok: got %b expected 0", resp.data_ok);
      end
      step();
      n_tests++;
      if (resp.data_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_c2_data_ok: got %b expected 0", resp.data_ok);
      end
      step();
      txn(BASE + 64'd16, 8'h00, 64'd0, rd, aok, lat);
      n_tests++;
      if (rd !== W2) begin
         n_fail++;
         $display("FAIL abort_word2: got %h expected %h", rd, W2);
      end
   endtask

   task automatic test_out_of_range();
      logic [63:0] rd;
      logic        aok;
      int          lat;
      txn(64'h7FFF_FFF8, 8'h00, 64'd0, rd, aok, lat);
      n_tests++;
      if (rd !== 64'd0 || lat !== 3) begin
         n_fail++;
         $display("FAIL oor_below: got data %h lat %0d expected 0 lat 3", rd, lat);
      end
      txn(BASE + 64'h8000, 8'h00, 64'd0, rd, aok, lat);
      n_tests++;
      if (rd !== 64'd0 || lat !== 3) begin
         n_fail++;
         $display("FAIL oor_above: got data %h lat %0d expected 0 lat 3", rd, lat);
      end
      txn(BASE + 64'h8000, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, rd, aok, lat);
      n_tests++;
      if (rd !== 64'd0 || aok !== 1'b1) begin
         n_fail++;
         $display("FAIL oor_write_resp: got data %h addr_ok %b expected 0 addr_ok 1", rd, aok);
      end
      txn(BASE, 8'h00, 64'd0, rd, aok, lat);
      n_tests++;
      if (rd !== W0) begin
         n_fail++;
         $display("FAIL oor_word0: got %h expected %h", rd, W0);
      end
      txn(BASE + 64'h7FF8, 8'h00, 64'd0, rd, aok, lat);
      n_tests++;
      if (rd !== WLAST) begin
         n_fail++;
         $display("FAIL oor_word_last: got %h expected %h", rd, WLAST);
      end
   endtask

   task automatic test_latency0();
      for (int i = 0; i < 4; i++) begin
         drive0(1'b1, BASE + 64'(8 * i), 8'hFF, l0_vals[i]);
         step();
         req0.valid = 1'b0;
         step();
      end
      drive0(1'b1, BASE, 8'h00, 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++;
         if (resp0.data_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL lat0_resp%0d_data_ok: got %b expected 1", i, resp0.data_ok);
         end
         n_tests++;
         if (resp0.data !== l0_vals[i]) begin
            n_fail++;
            $display("FAIL lat0_resp%0d_data: got %h expected %h", i, resp0.data, l0_vals[i]);
         end
         if (i < 3) req0.addr = BASE + 64'(8 * (i + 1));
         else       req0.valid = 1'b0;
         step();
         n_tests++;
         if (resp0.data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL lat0_gap%0d_data_ok: got %b expected 0", i, resp0.data_ok);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, BASE + 64'd24, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      reset = 1'b1;
      step();
      n_tests++;
      if (resp !== '0) begin
         n_fail++;
         $display("FAIL rstmid_after_reset: got %h expected 0", resp);
      end
      reset = 1'b0;
      drive(1'b1, BASE + 64'd24, 8'h00, 64'd0);
      step();
      n_tests++;
      if (resp !== '0) begin
         n_fail++;
         $display("FAIL rstmid_next_cycle: got %h expected 0", resp);
      end
      step();
      n_tests++;
      if (resp.data_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_wait_data_ok: got %b expected 0", resp.data_ok);
      end
      step();
      n_tests++;
      if (resp.data_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_resp_data_ok: got %b expected 1", resp.data_ok);
      end
      n_tests++;
      if (resp.data !== W3) begin
         n_fail++;
         $display("FAIL rstmid_word3: got %h expected %h", resp.data, W3);
      end
      req.valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      preload();
      test_read();
      test_strobe_write();
      test_abort();
      test_out_of_range();
      test_latency0();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
